// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if: control, data and status bundle for the universal shift register.
interface univ_shift_reg_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
);
   logic             en;
   logic [2:0]       mode;
   logic [WIDTH-1:0] d;
   logic             sin_l;
   logic             sin_r;
   logic             start;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] q;
   logic             sout_l;
   logic             sout_r;
   logic             busy;
   logic             done;
   modport master (
      output en, mode, d, sin_l, sin_r, start, count,
      input  q, sout_l, sout_r, busy, done
   );
   modport slave (
      input  en, mode, d, sin_l, sin_r, start, count,
      output q, sout_l, sout_r, busy, done
   );
endinterface

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register with direct ops and a counted shift/rotate burst engine.
module univ_shift_reg #(
   parameter int               WIDTH     = 8,
   parameter int               CNT_W     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input logic                clk,
   input logic                reset,
   univ_shift_reg_if.slave    bus
);
   typedef enum logic {S_IDLE, S_RUN} state_t;
   state_t           r_state, w_state_nxt;
   logic [2:0]       r_op;
   logic [CNT_W-1:0] r_rem;
   logic [WIDTH-1:0] r_q;
   logic             r_done;
   logic             w_shift_mode, w_accept, w_apply, w_done_nxt;
   logic [2:0]       w_op;
   logic [WIDTH-1:0] w_q_nxt;

   function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] op, input logic [WIDTH-1:0] v,
                                                 input logic [WIDTH-1:0] ld, input logic sl, input logic sr);
      case (op)
         3'd1:    apply_op = {v[WIDTH-2:0], sr};
         3'd2:    apply_op = {sl, v[WIDTH-1:1]};
         3'd3:    apply_op = {v[WIDTH-2:0], v[WIDTH-1]};
         3'd4:    apply_op = {v[0], v[WIDTH-1:1]};
         3'd5:    apply_op = {v[WIDTH-1], v[WIDTH-1:1]};
         3'd6:    apply_op = ld;
         3'd7:    apply_op = '0;
         default: apply_op = v;
      endcase
   endfunction

   assign w_shift_mode = (bus.mode != 3'd0) && (bus.mode <= 3'd5);
   assign w_accept     = (r_state == S_IDLE) && bus.start && w_shift_mode;

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == S_RUN) w_state_nxt = (r_rem == CNT_W'(1)) ? S_IDLE : S_RUN;
      else if (w_accept && bus.count != '0) w_state_nxt = S_RUN;
   end

   // Any start in IDLE, even an ignored one, blocks en for that cycle.
   always_comb begin
      w_apply    = (r_state == S_RUN) || (!bus.start && bus.en);
      w_op       = (r_state == S_RUN) ? r_op : bus.mode;
      w_done_nxt = (r_state == S_RUN) ? (r_rem == CNT_W'(1)) : (w_accept && bus.count == '0);
      w_q_nxt    = w_apply ? apply_op(w_op, r_q, bus.d, bus.sin_l, bus.sin_r) : r_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_q    <= RESET_VAL;
         r_done <= 1'b0;
         r_op   <= 3'd0;
         r_rem  <= '0;
      end else begin
         r_q    <= w_q_nxt;
         r_done <= w_done_nxt;
         if (w_accept) begin
            r_op  <= bus.mode;
            r_rem <= bus.count;
         end else if (r_state == S_RUN) begin
            r_rem <= r_rem - CNT_W'(1);
         end
      end
   end

   assign bus.q      = r_q;
   assign bus.sout_l = r_q[WIDTH-1];
   assign bus.sout_r = r_q[0];
   assign bus.busy   = (r_state == S_RUN);
   assign bus.done   = r_done;
endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register: the next step up from the single-bit DFF. WIDTH flops under one clock, with a synchronous active-low reset to a programmable value. Supports hold, logical and arithmetic shifts, rotates, parallel load and clear, one operation per enabled cycle. Adds a burst engine that applies one shift/rotate a programmed number of times under a busy/done handshake. Used as the general-purpose serialiser/deserialiser and bit-manipulation register in datapath blocks.

## Interface
- WIDTH, 8, register width (≥2)
- CNT_W, 4, width of burst count; max burst = 2^CNT_W−1
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset
- clk  input  1  rising-edge clock, sole clock
- reset  input  1  synchronous reset, active-low (reset=0 resets on the next rising clk edge)
- en  input  1  direct-operation enable; mode executed at edge when en=1 and idle
- mode  input  3  operation select (encoding below)
- d  input  WIDTH  parallel load data
- sin_l  input  1  serial input entering MSB (SHR)
- sin_r  input  1  serial input entering LSB (SHL)
- start  input  1  burst request, sampled when idle
- count  input  CNT_W  number of burst steps, sampled with start
- q  output  WIDTH  register contents
- sout_l  output  1  q[WIDTH-1], combinational from q
- sout_r  output  1  q[0], combinational from q
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse: burst complete

## Operation
- mode encoding:
  - 000 HOLD
  - 001 SHL: q <= {q[W-2:0], sin_r}
  - 010 SHR: q <= {sin_l, q[W-1:1]}
  - 011 ROL
  - 100 ROR
  - 101 ASR: MSB replicated
  - 110 LOAD: q <= d
  - 111 CLEAR: q <= 0 (zero, not RESET_VAL)
- FSM states:
  - IDLE:
    - start=1 and mode in {001..101} and count≠0 → RUN; latch mode into op_r, count into rem.
    - start=1, count=0, valid shift mode → stay IDLE, done=1 next cycle, q unchanged.
    - start=1 with mode in {000,110,111} → ignored entirely (no busy, no done); en also ignored that cycle.
    - start=0, en=1 → execute mode once.
  - RUN: each edge applies op_r once; rem decrements. Transition on the edge that applies the final step (rem==1) → IDLE, done=1.
- In RUN, start, en, mode and count are ignored. sin_l and sin_r are sampled live on every step.
- Precedence, highest first: reset, RUN step, start, en.
- Bursts longer than WIDTH are legal: shifts keep filling from the serial input; rotates wrap.

## Timing
- Reset (reset=0 at an edge): q=RESET_VAL, busy=0, done=0, state IDLE. Applies in any state; a burst in progress is aborted with no done pulse.
- Direct op: result visible in q one cycle after the en edge.
- Burst of N≥1, start sampled at edge k:
  - busy=1 after edges k..k+N−1 and falls after edge k+N.
  - Shifts occur at edges k+1..k+N.
  - done=1 for exactly the cycle after edge k+N, when q already holds the final value and busy=0.
  - A new start is accepted at edge k+N+1 at the earliest.
- count=0: done=1 for the cycle after edge k; busy stays 0.
- done is never high with busy high.
- All outputs are registered except sout_l and sout_r.

## Test plan
- Reset: hold reset=0 with en=1, mode=LOAD, d=0xA5 → q=0x00 after the edge. Release, repeat LOAD → q=0xA5.
- Direct ops from q=0x81 (WIDTH=8), reloaded each time:
  - ROL → 0x03
  - ROR → 0xC0
  - ASR → 0xC0
  - SHL with sin_r=1 → 0x03
  - SHR with sin_l=0 → 0x40
  - CLEAR → 0x00
  - HOLD → 0x81
- Burst: q=0x01, start with mode=ROL, count=3.
  - busy high exactly 3 cycles; q goes 0x02, 0x04, 0x08.
  - done one cycle with q=0x08, busy=0.
- Ignored requests: start with mode=LOAD → no busy, no done, q unchanged. start with count=0 → done next cycle, busy=0. During a ROR count=4 burst, pulse start and en with mode=LOAD → q follows the rotate only, one done.
- Reset mid-burst: ROR count=5 from 0x01; drive reset=0 after 2 steps → q=RESET_VAL, busy=0, no done; next burst works normally.
- WIDTH=16, RESET_VAL=0x1234: after reset q=0x1234. Burst SHL count=15 with sin_r=0 → q=0x0000, done asserted once.
